output_gain_stage: RTL



---
 rtl/audio_gain_pkg.sv | 23 ++
 rtl/output_gain_stage_if.sv | 25 ++
 rtl/gain_ramp.sv | 43 ++++
 rtl/output_gain_stage.sv | 109 ++++++++++
 4 files changed

// File: rtl/audio_gain_pkg.sv
// rtl/audio_gain_pkg.sv - shared types, constants and FSM encoding for the output gain stage
package audio_gain_pkg;

    typedef logic signed [15:0] sample_t;
    typedef logic [15:0]        gain_t;

    localparam int GAIN_UNITY = 16384;
    localparam int GAIN_STEP  = 2048;
    localparam int SAMPLE_MAX = 32767;
    localparam int SAMPLE_MIN = -32768;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_RND,
        ST_SAT
    } state_t;

    function automatic gain_t target_gain(input logic [3:0] sel, input logic mute);
        return mute ? gain_t'(0) : gain_t'(sel) * gain_t'(GAIN_STEP);
    endfunction

endpackage

// File: rtl/output_gain_stage_if.sv
// rtl/output_gain_stage_if.sv - sample, control and status signals of the output gain stage
interface output_gain_stage_if;
    import audio_gain_pkg::*;

    logic        sample_valid;
    sample_t     sample_in;
    logic [3:0]  gain_sel;
    logic        mute;
    sample_t     sample_out;
    logic        out_valid;
    logic        clip;
    logic        ramp_busy;
    logic        sample_drop;

    modport master (
        output sample_valid, sample_in, gain_sel, mute,
        input  sample_out, out_valid, clip, ramp_busy, sample_drop
    );

    modport slave (
        input  sample_valid, sample_in, gain_sel, mute,
        output sample_out, out_valid, clip, ramp_busy, sample_drop
    );

endinterface

// File: rtl/gain_ramp.sv
// rtl/gain_ramp.sv - slews the current gain toward the target by at most RAMP_STEP per advance
module gain_ramp
    import audio_gain_pkg::*;
#(
    parameter int RAMP_STEP = 256
) (
    input  logic  clk_144,
    input  logic  reset_n,
    input  gain_t g_tgt,
    input  logic  advance,
    output gain_t g_cur,
    output logic  ramp_busy
);

    localparam gain_t STEP = gain_t'(RAMP_STEP);

    gain_t g_next;
    gain_t diff;

    // Clamp to the target when within one step so the ramp never overshoots.
    always_comb begin
        g_next = g_cur;
        diff   = '0;
        if (g_tgt > g_cur) begin
            diff   = g_tgt - g_cur;
            g_next = (diff > STEP) ? g_cur + STEP : g_tgt;
        end else begin
            diff   = g_cur - g_tgt;
            g_next = (diff > STEP) ? g_cur - STEP : g_tgt;
        end
    end

    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            g_cur <= '0;
        end else if (advance) begin
            g_cur <= g_next;
        end
    end

    assign ramp_busy = (g_cur != g_tgt);

endmodule

// File: rtl/output_gain_stage.sv
// rtl/output_gain_stage.sv - slewed linear gain with round-half-up scaling, saturation and clip hold
module output_gain_stage
    import audio_gain_pkg::*;
#(
    parameter int GAIN_FRAC = 14,
    parameter int RAMP_STEP = 256,
    parameter int CLIP_HOLD = 4800
) (
    input  logic                 clk_144,
    input  logic                 reset_n,
    output_gain_stage_if.slave   bus
);

    localparam int                 CNT_W    = $clog2(CLIP_HOLD + 1);
    localparam logic signed [31:0] RND_HALF = 32'sd1 <<< (GAIN_FRAC - 1);
    localparam logic signed [31:0] LIM_HI   = SAMPLE_MAX;
    localparam logic signed [31:0] LIM_LO   = SAMPLE_MIN;

    state_t             state, state_nx;
    sample_t            sample_q;
    gain_t              g_cur;
    gain_t              g_tgt;
    logic               accept;
    logic               ramp_busy;
    logic signed [31:0] mul_a, mul_b;
    logic signed [31:0] product_q;
    logic signed [31:0] rounded_q;
    logic               sat_hi, sat_lo;
    sample_t            result_q;
    logic               result_vld;
    logic               result_sat;
    logic [CNT_W-1:0]   hold_cnt;

    assign g_tgt  = target_gain(bus.gain_sel, bus.mute);
    assign accept = (state == ST_IDLE) && bus.sample_valid;

    gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp (
        .clk_144   (clk_144),
        .reset_n   (reset_n),
        .g_tgt     (g_tgt),
        .advance   (accept),
        .g_cur     (g_cur),
        .ramp_busy (ramp_busy)
    );

    assign bus.ramp_busy = ramp_busy;

    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (bus.sample_valid) state_nx = ST_MUL;
            ST_MUL:  state_nx = ST_RND;
            ST_RND:  state_nx = ST_SAT;
            ST_SAT:  state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    assign mul_a  = 32'(sample_q);
    assign mul_b  = 32'($signed({1'b0, g_cur}));
    assign sat_hi = rounded_q > LIM_HI;
    assign sat_lo = rounded_q < LIM_LO;

    // The saturated result waits one register so the output lands one cycle after SAT.
    always_ff @(posedge clk_144 or negedge reset_n) begin
        if (!reset_n) begin
            sample_q        <= '0;
            product_q       <= '0;
            rounded_q       <= '0;
            result_q        <= '0;
            result_vld      <= 1'b0;
            result_sat      <= 1'b0;
            hold_cnt        <= '0;
            bus.sample_out  <= '0;
            bus.out_valid   <= 1'b0;
            bus.clip        <= 1'b0;
            bus.sample_drop <= 1'b0;
        end else begin
            result_vld      <= 1'b0;
            bus.out_valid   <= result_vld;
            bus.sample_drop <= bus.sample_valid && (state != ST_IDLE);
            if (accept) sample_q <= bus.sample_in;
            if (state == ST_MUL) product_q <= mul_a * mul_b;
            if (state == ST_RND) rounded_q <= (product_q + RND_HALF) >>> GAIN_FRAC;
            if (state == ST_SAT) begin
                result_q   <= sat_hi ? sample_t'(SAMPLE_MAX) :
                              sat_lo ? sample_t'(SAMPLE_MIN) : rounded_q[15:0];
                result_sat <= sat_hi || sat_lo;
                result_vld <= 1'b1;
            end
            if (result_vld) begin
                bus.sample_out <= result_q;
                if (result_sat) begin
                    hold_cnt <= CNT_W'(CLIP_HOLD);
                    bus.clip <= 1'b1;
                end else if (hold_cnt != '0) begin
                    hold_cnt <= hold_cnt - 1'b1;
                    if (hold_cnt == CNT_W'(1)) bus.clip <= 1'b0;
                end
            end
        end
    end

endmodule
